fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_skid.sv | 51 +++++
 rtl/fetch_stage.sv | 184 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage: datapath width, the
// PC step between sequential fetches, the fetch FSM state encoding and a
// helper that forces word alignment on a PC value.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // BOOT : one idle cycle after reset release
  // REQ  : request outstanding at r_pc
  // HOLD : fetched word parked in the skid register while stalled
  // DROP : redirect seen before the ack; wait for the old ack and discard it
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetchState_e;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pcIn);
    return {pcIn[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_skid.sv
// fetch_skid
// One-entry skid register holding an instruction word and its PC when the
// memory returns data while the IF/ID register is stalled.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_load            capture i_data / i_pc
//   i_drain           entry consumed by IF/ID
//   i_flush           discard the entry (redirect); wins over load/drain
//   i_data, i_pc      word and PC to capture
//   o_valid           entry holds a word
//   o_data, o_pc      stored word and PC
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage: issues word requests to instruction memory,
// delivers returned words into the IF/ID register, absorbs stalls through a
// one-entry skid register and handles redirects (jumps), including jumps that
// arrive while a request is still unacknowledged.
// Build option: define FETCH_PERF_EN to add the performance counter outputs.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_stall                     hold IF/ID
//   i_jmp, i_jmp_target         one-cycle redirect request and target PC
//   o_imem_req, o_imem_addr     memory request and its word address
//   i_imem_ack, i_imem_rdata    memory accept + returned word (same cycle)
//   o_instr, o_instr_pc         IF/ID instruction and its PC
//   o_instr_valid               IF/ID holds a live instruction
//   o_fetch_wait                request outstanding and not acked this cycle
//   o_perf_fetch_cnt            (FETCH_PERF_EN) IF/ID loads with valid=1
//   o_perf_stall_cnt            (FETCH_PERF_EN) cycles with i_stall=1
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_jmp,
  input  logic [XLEN-1:0] i_jmp_target,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  output logic            o_instr_valid,
  output logic            o_fetch_wait
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] o_perf_fetch_cnt,
  output logic [XLEN-1:0] o_perf_stall_cnt
`endif
);

  localparam logic [XLEN-1:0] BOOT_PC = alignPc(RESET_PC);

  fetchState_e     r_state;
  logic            r_imemReq;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instrPc;
  logic            r_instrValid;

  logic [XLEN-1:0] w_jmpPc;
  logic            w_skidValid;
  logic [XLEN-1:0] w_skidData;
  logic [XLEN-1:0] w_skidPc;
  logic            w_loadFromMem;
  logic            w_loadFromSkid;
  logic            w_skidLoad;
  logic            w_ifidLoad;

  assign w_jmpPc = alignPc(i_jmp_target);

  // A jump always cancels whatever would have been written this cycle.
  assign w_loadFromMem  = (r_state == REQ)  & i_imem_ack & ~i_jmp & ~i_stall;
  assign w_loadFromSkid = (r_state == HOLD) & w_skidValid & ~i_jmp & ~i_stall;
  assign w_skidLoad     = (r_state == REQ)  & i_imem_ack & ~i_jmp & i_stall;
  assign w_ifidLoad     = w_loadFromMem | w_loadFromSkid;

  fetch_skid u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_skidLoad),
    .i_drain (w_loadFromSkid),
    .i_flush (i_jmp),
    .i_data  (i_imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_skidValid),
    .o_data  (w_skidData),
    .o_pc    (w_skidPc)
  );

  // Request FSM. r_pc is the address of the outstanding request and only
  // moves on an ack (or while no request is outstanding), keeping the
  // request stable until it is accepted. In DROP r_target holds the latest
  // redirect; the old request's ack is consumed and discarded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= BOOT;
      r_imemReq <= 1'b0;
      r_pc      <= BOOT_PC;
      r_target  <= BOOT_PC;
    end else begin
      unique case (r_state)
        BOOT: begin
          r_state   <= REQ;
          r_imemReq <= 1'b1;
          if (i_jmp) r_pc <= w_jmpPc;
        end
        REQ: begin
          if (i_jmp) begin
            if (i_imem_ack) begin
              r_pc <= w_jmpPc;
            end else begin
              r_state  <= DROP;
              r_target <= w_jmpPc;
            end
          end else if (i_imem_ack) begin
            r_pc <= r_pc + PC_INC;
            if (i_stall) begin
              r_state   <= HOLD;
              r_imemReq <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (i_jmp) begin
            r_pc      <= w_jmpPc;
            r_state   <= REQ;
            r_imemReq <= 1'b1;
          end else if (!i_stall) begin
            r_state   <= REQ;
            r_imemReq <= 1'b1;
          end
        end
        DROP: begin
          if (i_imem_ack) begin
            r_pc    <= i_jmp ? w_jmpPc : r_target;
            r_state <= REQ;
          end else if (i_jmp) begin
            r_target <= w_jmpPc;
          end
        end
        default: begin
          r_state   <= BOOT;
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: jump kills, stall holds, otherwise load or bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr      <= '0;
      r_instrPc    <= '0;
      r_instrValid <= 1'b0;
    end else if (i_jmp) begin
      r_instrValid <= 1'b0;
    end else if (w_ifidLoad) begin
      r_instr      <= w_loadFromSkid ? w_skidData : i_imem_rdata;
      r_instrPc    <= w_loadFromSkid ? w_skidPc : r_pc;
      r_instrValid <= 1'b1;
    end else if (!i_stall) begin
      r_instrValid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] r_perfFetchCnt;
  logic [XLEN-1:0] r_perfStallCnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perfFetchCnt <= '0;
      r_perfStallCnt <= '0;
    end else begin
      if (w_ifidLoad) r_perfFetchCnt <= r_perfFetchCnt + 32'd1;
      if (i_stall)    r_perfStallCnt <= r_perfStallCnt + 32'd1;
    end
  end

  assign o_perf_fetch_cnt = r_perfFetchCnt;
  assign o_perf_stall_cnt = r_perfStallCnt;
`endif

  assign o_imem_req    = r_imemReq;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instrPc;
  assign o_instr_valid = r_instrValid;
  assign o_fetch_wait  = r_imemReq & ~i_imem_ack;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized stall / jump / ack traffic, all compared against a behavioural
// fetch model that tracks the request PC, a pending-discard flag and a
// queue for the parked word. Perf checks compile in with FETCH_PERF_EN.
module tb_fetch_stage;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_jmp;
  logic [31:0] i_jmp_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        o_fetch_wait;
`ifdef FETCH_PERF_EN
  logic [31:0] o_perf_fetch_cnt;
  logic [31:0] o_perf_stall_cnt;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_stall       (i_stall),
    .i_jmp         (i_jmp),
    .i_jmp_target  (i_jmp_target),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .o_instr_valid (o_instr_valid),
    .o_fetch_wait  (o_fetch_wait)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetch_cnt (o_perf_fetch_cnt),
    .o_perf_stall_cnt (o_perf_stall_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checkCount;
  int errorCount;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } parkedWord_t;

  // Reference model state
  bit          mBoot;
  bit          mReq;
  logic [31:0] mPc;
  bit          mDiscard;
  logic [31:0] mTarget;
  parkedWord_t parkQ[$];
  logic [31:0] mInstr;
  logic [31:0] mInstrPc;
  bit          mValid;
  logic [31:0] mFetchCnt;
  logic [31:0] mStallCnt;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBoot     = 1'b1;
    mReq      = 1'b0;
    mPc       = 32'h0;
    mDiscard  = 1'b0;
    mTarget   = 32'h0;
    parkQ.delete();
    mInstr    = 32'h0;
    mInstrPc  = 32'h0;
    mValid    = 1'b0;
    mFetchCnt = 32'h0;
    mStallCnt = 32'h0;
  endtask

  // One clock of fetch behaviour expressed in terms of requests, redirects
  // and the parked-word queue.
  task automatic modelStep(input bit sStall, input bit sJmp, input logic [31:0] sTarget,
                           input bit sAck, input logic [31:0] sData);
    logic [31:0] jt;
    parkedWord_t e;
    jt = sTarget & 32'hFFFF_FFFC;
    if (sStall) mStallCnt = mStallCnt + 1;
    if (mBoot) begin
      mBoot = 1'b0;
      mReq  = 1'b1;
      if (sJmp) begin
        mPc = jt;
        mValid = 1'b0;
      end else if (!sStall) mValid = 1'b0;
    end else if (sJmp) begin
      mValid = 1'b0;
      parkQ.delete();
      if (mReq && !sAck) begin
        mDiscard = 1'b1;
        mTarget  = jt;
      end else begin
        mPc      = jt;
        mReq     = 1'b1;
        mDiscard = 1'b0;
      end
    end else if (mReq && sAck) begin
      if (mDiscard) begin
        mDiscard = 1'b0;
        mPc = mTarget;
        if (!sStall) mValid = 1'b0;
      end else if (!sStall) begin
        mInstr = sData;
        mInstrPc = mPc;
        mValid = 1'b1;
        mFetchCnt = mFetchCnt + 1;
        mPc = mPc + 32'd4;
      end else begin
        e.pc = mPc;
        e.data = sData;
        parkQ.push_back(e);
        mPc = mPc + 32'd4;
        mReq = 1'b0;
      end
    end else if (parkQ.size() > 0) begin
      if (!sStall) begin
        e = parkQ.pop_front();
        mInstr = e.data;
        mInstrPc = e.pc;
        mValid = 1'b1;
        mFetchCnt = mFetchCnt + 1;
        mReq = 1'b1;
      end
    end else if (!sStall) begin
      mValid = 1'b0;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".imemReq"}, {31'b0, o_imem_req}, {31'b0, mReq});
    checkOutput({tag, ".imemAddr"}, o_imem_addr, mPc);
    checkOutput({tag, ".instrValid"}, {31'b0, o_instr_valid}, {31'b0, mValid});
    checkOutput({tag, ".instr"}, o_instr, mInstr);
    checkOutput({tag, ".instrPc"}, o_instr_pc, mInstrPc);
`ifdef FETCH_PERF_EN
    checkOutput({tag, ".perfFetch"}, o_perf_fetch_cnt, mFetchCnt);
    checkOutput({tag, ".perfStall"}, o_perf_stall_cnt, mStallCnt);
`endif
  endtask

  // Called at a falling edge: drive inputs, check fetch_wait, clock the
  // model at the rising edge and compare at the next falling edge.
  task automatic applyStimulus(input string tag, input bit stall, input bit jmp,
                               input logic [31:0] target, input bit ack);
    logic [31:0] data;
    data = ack ? memWord(mPc) : $urandom;
    i_stall      = stall;
    i_jmp        = jmp;
    i_jmp_target = target;
    i_imem_ack   = ack;
    i_imem_rdata = data;
    #1;
    checkOutput({tag, ".fetchWait"}, {31'b0, o_fetch_wait}, {31'b0, mReq & ~ack});
    @(posedge i_clk);
    modelStep(stall, jmp, target, ack, data);
    @(negedge i_clk);
    compareAll(tag);
  endtask

  // Asynchronous reset asserted between edges with a stray ack held high.
  task automatic doReset();
    #2;
    i_imem_ack = 1'b1;
    i_rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst.imemReq", {31'b0, o_imem_req}, 32'h0);
    checkOutput("rst.imemAddr", o_imem_addr, 32'h0);
    checkOutput("rst.instr", o_instr, 32'h0);
    checkOutput("rst.instrPc", o_instr_pc, 32'h0);
    checkOutput("rst.instrValid", {31'b0, o_instr_valid}, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    i_rst_n      = 1'b0;
    i_stall      = 1'b0;
    i_jmp        = 1'b0;
    i_jmp_target = 32'h0;
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'h0;
    modelReset();
    @(negedge i_clk);

    // Straight-line fetch: instr_pc 0,4,8 on consecutive cycles; a late ack
    // during the boot cycle is ignored.
    doReset();
    applyStimulus("boot", 0, 0, 32'h0, 1);
    checkOutput("boot.req", {31'b0, o_imem_req}, 32'h1);
    applyStimulus("seq0", 0, 0, 32'h0, 1);
    checkOutput("seq0.pc", o_instr_pc, 32'h0);
    checkOutput("seq0.valid", {31'b0, o_instr_valid}, 32'h1);
    applyStimulus("seq1", 0, 0, 32'h0, 1);
    checkOutput("seq1.pc", o_instr_pc, 32'h4);
    applyStimulus("seq2", 0, 0, 32'h0, 1);
    checkOutput("seq2.pc", o_instr_pc, 32'h8);

    // Stall while pc=8 is acked: IF/ID holds pc=4, then pc=8 then pc=12.
    doReset();
    applyStimulus("stBoot", 0, 0, 32'h0, 0);
    applyStimulus("st0", 0, 0, 32'h0, 1);
    applyStimulus("st4", 0, 0, 32'h0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("stHold", 1, 0, 32'h0, (k == 0));
      checkOutput("stHold.pc", o_instr_pc, 32'h4);
      checkOutput("stHold.valid", {31'b0, o_instr_valid}, 32'h1);
    end
    applyStimulus("stDrain", 0, 0, 32'h0, 0);
    checkOutput("stDrain.pc", o_instr_pc, 32'h8);
    checkOutput("stDrain.nextAddr", o_imem_addr, 32'hC);
    applyStimulus("stNext", 0, 0, 32'h0, 1);
    checkOutput("stNext.pc", o_instr_pc, 32'hC);

    // Jump while pc=0xC is unacked: old data dropped, next instr at 0x100.
    doReset();
    applyStimulus("jdBoot", 0, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++) applyStimulus("jdSeq", 0, 0, 32'h0, 1);
    applyStimulus("jdJmp", 0, 1, 32'h100, 0);
    checkOutput("jdJmp.addr", o_imem_addr, 32'hC);
    checkOutput("jdJmp.valid", {31'b0, o_instr_valid}, 32'h0);
    applyStimulus("jdWait", 0, 0, 32'h0, 0);
    applyStimulus("jdAck", 0, 0, 32'h0, 1);
    checkOutput("jdAck.valid", {31'b0, o_instr_valid}, 32'h0);
    checkOutput("jdAck.addr", o_imem_addr, 32'h100);
    applyStimulus("jdNew", 0, 0, 32'h0, 1);
    checkOutput("jdNew.pc", o_instr_pc, 32'h100);

    // Jump and stall together, misaligned target.
    doReset();
    applyStimulus("jsBoot", 0, 0, 32'h0, 0);
    applyStimulus("js0", 0, 0, 32'h0, 1);
    applyStimulus("jsJmp", 1, 1, 32'h203, 1);
    checkOutput("jsJmp.valid", {31'b0, o_instr_valid}, 32'h0);
    checkOutput("jsJmp.addr", o_imem_addr, 32'h200);

    // PC wrap, then reset in the middle of an outstanding request.
    doReset();
    applyStimulus("wrBoot", 0, 0, 32'h0, 0);
    applyStimulus("wrJmp", 0, 1, 32'hFFFF_FFFC, 1);
    applyStimulus("wrTop", 0, 0, 32'h0, 1);
    checkOutput("wrTop.pc", o_instr_pc, 32'hFFFF_FFFC);
    checkOutput("wrTop.addr", o_imem_addr, 32'h0);
    applyStimulus("wrPend", 0, 0, 32'h0, 0);
    doReset();
    applyStimulus("wrBoot2", 0, 0, 32'h0, 1);

`ifdef FETCH_PERF_EN
    // 5 fetches with 2 stall cycles.
    doReset();
    applyStimulus("pfBoot", 0, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++) applyStimulus("pfSeq", 0, 0, 32'h0, 1);
    applyStimulus("pfSt0", 1, 0, 32'h0, 1);
    applyStimulus("pfSt1", 1, 0, 32'h0, 0);
    applyStimulus("pfDrain", 0, 0, 32'h0, 0);
    applyStimulus("pfLast", 0, 0, 32'h0, 1);
    checkOutput("pf.fetchCnt", o_perf_fetch_cnt, 32'd5);
    checkOutput("pf.stallCnt", o_perf_stall_cnt, 32'd2);
`endif

    // Randomized traffic.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      bit          rStall;
      bit          rJmp;
      bit          rAck;
      logic [31:0] rTarget;
      rStall  = ($urandom_range(0, 99) < 25);
      rJmp    = ($urandom_range(0, 99) < 8);
      rAck    = ($urandom_range(0, 99) < 60);
      rTarget = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      applyStimulus("rnd", rStall, rJmp, rTarget, rAck);
      if (n == 1500) begin
        doReset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
